// File: rtl/clock_pkg.sv
// Shared constants for the clock-setting datapath: FSM state encoding
// and default tick counts at the 8.192 kHz system tick.
package clock_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_PRESSED = 2'd1;
   localparam logic [1:0] ST_LONG    = 2'd2;

   localparam int LONG_TICKS_1S      = 8192;
   localparam int REPEAT_TICKS_200MS = 1638;

   typedef enum logic [1:0] {
      S_IDLE    = ST_IDLE,
      S_PRESSED = ST_PRESSED,
      S_LONG    = ST_LONG
   } btn_state_t;

endpackage

// File: rtl/button_event_if.sv
// Debounced button level in, single-cycle button events out.
// slave = event generator side, master = consumer/driver side.
interface button_event_if;

   logic i_debounced;
   logic o_press;
   logic o_release;
   logic o_short;
   logic o_long;
   logic o_repeat;
   logic o_held;

   modport slave (
      input  i_debounced,
      output o_press, o_release, o_short,
      output o_long, o_repeat, o_held
   );

   modport master (
      output i_debounced,
      input  o_press, o_release, o_short,
      input  o_long, o_repeat, o_held
   );

endinterface

// File: rtl/button_event.sv
// Button level to press/release/short/long/repeat events.
// Auto-repeat is built only when BUTTON_EVENT_REPEAT_EN is defined.
module button_event
   import clock_pkg::*;
#(
   parameter int LONG_TICKS   = LONG_TICKS_1S,
   parameter int REPEAT_TICKS = REPEAT_TICKS_200MS,
   parameter int CNT_W        = 14
) (
   input  logic           i_clk,
   input  logic           i_rst,
   button_event_if.slave  bus
);

   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);

   if (LONG_TICKS < 2 || LONG_TICKS > (1 << CNT_W)) begin : g_bad_long
      $error("button_event: LONG_TICKS out of range");
   end

   if (REPEAT_TICKS < 2 || REPEAT_TICKS > (1 << CNT_W)) begin : g_bad_rep
      $error("button_event: REPEAT_TICKS out of range");
   end

   btn_state_t       state;
   logic [CNT_W-1:0] cnt;
   logic             prev;
   logic             rise;
   logic             fall;

   assign rise = bus.i_debounced & ~prev;
   assign fall = ~bus.i_debounced & prev;

   // state is registered, so held is a registered level too
   assign bus.o_held = (state != S_IDLE);

`ifdef BUTTON_EVENT_REPEAT_EN
   localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_TICKS - 1);

   // edge detect, hold counter, FSM and registered event pulses
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state         <= S_IDLE;
         cnt           <= '0;
         prev          <= 1'b0;
         bus.o_press   <= 1'b0;
         bus.o_release <= 1'b0;
         bus.o_short   <= 1'b0;
         bus.o_long    <= 1'b0;
         bus.o_repeat  <= 1'b0;
      end else begin
         prev          <= bus.i_debounced;
         bus.o_press   <= 1'b0;
         bus.o_release <= 1'b0;
         bus.o_short   <= 1'b0;
         bus.o_long    <= 1'b0;
         bus.o_repeat  <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (rise) begin
                  bus.o_press <= 1'b1;
                  cnt         <= '0;
                  state       <= S_PRESSED;
               end
            end
            S_PRESSED: begin
               if (fall) begin
                  bus.o_release <= 1'b1;
                  bus.o_short   <= 1'b1;
                  state         <= S_IDLE;
               end else if (cnt == LONG_LAST) begin
                  bus.o_long <= 1'b1;
                  cnt        <= '0;
                  state      <= S_LONG;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_LONG: begin
               if (fall) begin
                  bus.o_release <= 1'b1;
                  state         <= S_IDLE;
               end else if (cnt == REP_LAST) begin
                  bus.o_repeat <= 1'b1;
                  cnt          <= '0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= S_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end
`else
   assign bus.o_repeat = 1'b0;

   // edge detect, hold counter, FSM and registered event pulses
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state         <= S_IDLE;
         cnt           <= '0;
         prev          <= 1'b0;
         bus.o_press   <= 1'b0;
         bus.o_release <= 1'b0;
         bus.o_short   <= 1'b0;
         bus.o_long    <= 1'b0;
      end else begin
         prev          <= bus.i_debounced;
         bus.o_press   <= 1'b0;
         bus.o_release <= 1'b0;
         bus.o_short   <= 1'b0;
         bus.o_long    <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (rise) begin
                  bus.o_press <= 1'b1;
                  cnt         <= '0;
                  state       <= S_PRESSED;
               end
            end
            S_PRESSED: begin
               if (fall) begin
                  bus.o_release <= 1'b1;
                  bus.o_short   <= 1'b1;
                  state         <= S_IDLE;
               end else if (cnt == LONG_LAST) begin
                  bus.o_long <= 1'b1;
                  cnt        <= '0;
                  state      <= S_LONG;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            S_LONG: begin
               cnt <= '0;
               if (fall) begin
                  bus.o_release <= 1'b1;
                  state         <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end
`endif

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event with LONG_TICKS=8, REPEAT_TICKS=3.
// Expected per-cycle event vectors are queued as stimulus is driven.
module tb_button_event;

   localparam int P  = 0;
   localparam int RL = 1;
   localparam int SH = 2;
   localparam int LG = 3;
   localparam int RP = 4;
   localparam int HD = 5;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;

   logic [5:0] exp_v [0:63];
   logic [5:0] exp_q [$];

   button_event_if bif();

   button_event #(
      .LONG_TICKS   (8),
      .REPEAT_TICKS (3),
      .CNT_W        (14)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bif.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] observed();
      return {bif.o_held, bif.o_repeat, bif.o_long,
              bif.o_short, bif.o_release, bif.o_press};
   endfunction

   task automatic clear_exp();
      for (int i = 0; i < 64; i++) exp_v[i] = '0;
   endtask

   task automatic mark(input int b, input int c);
      exp_v[c][b] = 1'b1;
   endtask

   task automatic held(input int a, input int z);
      for (int i = a; i <= z; i++) exp_v[i][HD] = 1'b1;
   endtask

   // cycle c: input set after edge c, outputs read #1 after edge c+1
   task automatic run(input string tag, input int ncyc,
                      input int rise, input int fall,
                      input int rst_at);
      logic [5:0] got;
      logic [5:0] want;
      for (int c = 0; c < ncyc; c++) begin
         bif.i_debounced = (rise >= 0) && (c >= rise) &&
                           ((fall < 0) || (c < fall));
         rst = (c == rst_at);
         exp_q.push_back(exp_v[c+1]);
         @(posedge clk);
         #1;
         got  = observed();
         want = exp_q.pop_front();
         checks++;
         assert (got === want) else begin
            failures++;
            $error("FAIL %s cycle %0d got=%b exp=%b (held,rep,long,short,rel,press)",
                   tag, c + 1, got, want);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      logic [5:0] got;
      rst = 1'b1;
      bif.i_debounced = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      got = observed();
      checks++;
      assert (got === 6'b0) else begin
         failures++;
         $error("FAIL reset_state got=%b exp=%b", got, 6'b0);
      end
      rst = 1'b0;

      clear_exp();
      run("idle", 20, -1, -1, -1);

      clear_exp();
      mark(P, 1); mark(RL, 6); mark(SH, 6); held(1, 5);
      run("short", 8, 0, 5, -1);

      clear_exp();
      mark(P, 1); mark(LG, 9); mark(RL, 21); held(1, 20);
`ifdef BUTTON_EVENT_REPEAT_EN
      mark(RP, 12); mark(RP, 15); mark(RP, 18);
`endif
      run("long_rep", 23, 0, 20, -1);

      clear_exp();
      mark(P, 1); mark(RL, 9); mark(SH, 9); held(1, 8);
      run("rel_on_long", 10, 0, 8, -1);

      clear_exp();
      mark(P, 1); mark(LG, 9); mark(RL, 12); held(1, 11);
      run("rel_on_rep", 13, 0, 11, -1);

      clear_exp();
      mark(P, 1); held(1, 4);
      mark(P, 6); mark(LG, 14); mark(RL, 17); held(6, 16);
      run("rst_mid", 18, 0, 16, 4);

      clear_exp();
      mark(P, 1); mark(LG, 9); mark(RL, 31); held(1, 30);
`ifdef BUTTON_EVENT_REPEAT_EN
      for (int k = 12; k <= 30; k += 3) mark(RP, k);
`endif
      run("hold30", 33, 0, 30, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
